// File: rtl/billiard_pkg.sv
// Shared types and default tuning constants for the billiard shot controller.
package billiard_pkg;

  typedef enum logic [1:0] {
    MOVING    = 2'd0,
    AIM       = 2'd1,
    FIRE      = 2'd2,
    WAIT_MOVE = 2'd3
  } shot_state_t;

  localparam int DEF_MAX_STEPS     = 5;
  localparam int DEF_REPEAT_DELAY  = 15;
  localparam int DEF_REPEAT_PERIOD = 5;

endpackage

// File: rtl/key_repeat.sv
// One direction key: rising-edge detect plus frame-based auto-repeat request.
module key_repeat #(
  parameter int REPEAT_DELAY  = 15,
  parameter int REPEAT_PERIOD = 5,
  parameter int CW            = 4
) (
  input  logic clk,
  input  logic resetN,
  input  logic i_key,
  input  logic i_en,
  input  logic i_block,
  input  logic i_sof,
  output logic o_req
);

  logic          r_key_prev;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_active;
  logic          w_edge;
  logic          w_repeat;

  assign w_active  = i_en & i_key & ~i_block;
  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_edge    = i_key & ~r_key_prev;
  assign w_repeat  = i_sof && (w_cnt_inc == CW'(REPEAT_DELAY));
  assign o_req     = w_active & (w_edge | w_repeat);

  // After the first repeat the counter is rewound by one period, so every
  // later repeat lands when it climbs back to REPEAT_DELAY.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_key_prev <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_key_prev <= i_key;
      if (!w_active)
        r_cnt <= '0;
      else if (w_repeat)
        r_cnt <= CW'(REPEAT_DELAY - REPEAT_PERIOD);
      else if (i_sof)
        r_cnt <= w_cnt_inc;
    end
  end

endmodule

// File: rtl/shot_input_ctrl.sv
// Cue-ball shot controller: waits for the ball to settle, collects charge
// pulses from the direction keys, and fires on the shoot key.
module shot_input_ctrl
  import billiard_pkg::*;
#(
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int STILL_FRAMES  = 4,
  parameter int MOVE_TIMEOUT  = 8,
  parameter int MAX_STEPS     = DEF_MAX_STEPS
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               keyUp,
  input  logic               keyDown,
  input  logic               keyLeft,
  input  logic               keyRight,
  input  logic               keySpace,
  input  logic signed [10:0] topLeftX,
  input  logic signed [10:0] topLeftY,
  output logic               chargeUp,
  output logic               chargeDown,
  output logic               chargeLeft,
  output logic               chargeRight,
  output logic               releaseBall,
  output logic signed [3:0]  powerX,
  output logic signed [3:0]  powerY,
  output logic               aiming
);

  localparam int SW = $clog2(STILL_FRAMES + 1);
  localparam int MW = $clog2(MOVE_TIMEOUT + 1);
  localparam int CW = $clog2(REPEAT_DELAY + 1);
  localparam logic signed [3:0] P_MAX = 4'(MAX_STEPS);
  localparam logic signed [3:0] P_MIN = -4'(MAX_STEPS);

  shot_state_t        r_state;
  shot_state_t        w_state_next;
  logic signed [10:0] r_prev_x;
  logic signed [10:0] r_prev_y;
  logic [SW-1:0]      r_still_cnt;
  logic [MW-1:0]      r_frame_cnt;
  logic               r_space_prev;
  logic [3:0]         r_pulse;
  logic signed [3:0]  r_power_x;
  logic signed [3:0]  r_power_y;

  logic               w_same;
  logic               w_stationary;
  logic               w_aim;
  logic               w_fire_now;
  logic [3:0]         w_key;
  logic [3:0]         w_block;
  logic [3:0]         w_req;
  logic [3:0]         w_ok;
  logic [3:0]         w_pulse_next;

  assign w_same       = (topLeftX == r_prev_x) && (topLeftY == r_prev_y);
  assign w_stationary = (r_still_cnt == SW'(STILL_FRAMES));
  assign w_aim        = (r_state == AIM);
  assign w_fire_now   = w_aim & keySpace & ~r_space_prev;

  // Bit order everywhere: 0 up, 1 down, 2 left, 3 right.
  assign w_key   = {keyRight, keyLeft, keyDown, keyUp};
  assign w_block = {{2{keyLeft & keyRight}}, {2{keyUp & keyDown}}};
  assign w_ok    = {r_power_x != P_MIN, r_power_x != P_MAX,
                    r_power_y != P_MIN, r_power_y != P_MAX};
  assign w_pulse_next = w_req & w_ok & {4{~w_fire_now}};

  for (genvar gi = 0; gi < 4; gi++) begin : g_key
    key_repeat #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .CW           (CW)
    ) u_key_repeat (
      .clk    (clk),
      .resetN (resetN),
      .i_key  (w_key[gi]),
      .i_en   (w_aim),
      .i_block(w_block[gi]),
      .i_sof  (startOfFrame),
      .o_req  (w_req[gi])
    );
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      MOVING:    if (w_stationary) w_state_next = AIM;
      AIM:       if (w_fire_now) w_state_next = FIRE;
                 else if (!w_stationary) w_state_next = MOVING;
      FIRE:      w_state_next = WAIT_MOVE;
      WAIT_MOVE: if (startOfFrame &&
                     (!w_same || r_frame_cnt == MW'(MOVE_TIMEOUT - 1)))
                   w_state_next = MOVING;
      default:   w_state_next = MOVING;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state      <= MOVING;
      r_prev_x     <= '0;
      r_prev_y     <= '0;
      r_still_cnt  <= '0;
      r_frame_cnt  <= '0;
      r_space_prev <= 1'b0;
      r_pulse      <= '0;
      r_power_x    <= '0;
      r_power_y    <= '0;
    end else begin
      r_state      <= w_state_next;
      r_space_prev <= keySpace;
      r_pulse      <= w_pulse_next;
      if (startOfFrame) begin
        r_prev_x <= topLeftX;
        r_prev_y <= topLeftY;
      end
      // Stillness is only tracked outside a shot so a timed-out shot must
      // see a fresh run of still frames before aiming again.
      if (r_state == FIRE || r_state == WAIT_MOVE)
        r_still_cnt <= '0;
      else if (startOfFrame)
        r_still_cnt <= !w_same ? '0 :
                       w_stationary ? r_still_cnt : r_still_cnt + SW'(1);
      if (r_state != WAIT_MOVE)
        r_frame_cnt <= '0;
      else if (startOfFrame)
        r_frame_cnt <= r_frame_cnt + MW'(1);
      if (w_fire_now) begin
        r_power_x <= '0;
        r_power_y <= '0;
      end else begin
        if (w_pulse_next[0])      r_power_y <= r_power_y + 4'sd1;
        else if (w_pulse_next[1]) r_power_y <= r_power_y - 4'sd1;
        if (w_pulse_next[2])      r_power_x <= r_power_x + 4'sd1;
        else if (w_pulse_next[3]) r_power_x <= r_power_x - 4'sd1;
      end
    end
  end

  assign chargeUp    = r_pulse[0];
  assign chargeDown  = r_pulse[1];
  assign chargeLeft  = r_pulse[2];
  assign chargeRight = r_pulse[3];
  assign powerX      = r_power_x;
  assign powerY      = r_power_y;
  assign aiming      = (r_state == AIM);
  assign releaseBall = (r_state == FIRE);

endmodule
